// File: rtl/regfile_requester.sv
// Register-file initiator: one command (up to two reads + one write) run as serial four-phase re/rack, we/wack handshakes.
// Latency is SYNC_STAGES cycles per REQ/REL state with an instant responder; cmd_ready only in IDLE, the response is held until rsp_ready.
module regfile_requester #(
  parameter int REG_SZ      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd_a,
  input  logic              cmd_rd_b,
  input  logic              cmd_wr,
  input  logic [4:0]        cmd_ra,
  input  logic [4:0]        cmd_rb,
  input  logic [4:0]        cmd_wa,
  input  logic [REG_SZ-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_SZ-1:0] rsp_a,
  output logic [REG_SZ-1:0] rsp_b,
  output logic              rsp_err,
  output logic [4:0]        rf_r_idx,
  output logic              rf_re,
  input  logic              rf_rack,
  input  logic [REG_SZ-1:0] rf_dout,
  output logic [4:0]        rf_w_idx,
  output logic [REG_SZ-1:0] rf_din,
  output logic              rf_we,
  input  logic              rf_wack
);

  localparam int SW = SYNC_STAGES - 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RA_REQ, S_RA_REL, S_RB_REQ, S_RB_REL,
    S_W_REQ, S_W_REL, S_ABORT, S_RESP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_rack_sync, r_wack_sync;
  logic              w_rack, w_wack;
  logic [TW-1:0]     r_tmo;
  logic              w_tmo_hit, w_req_enter, w_accept, w_cmd_wr_en;
  logic              r_rd_b, r_wr;
  logic [4:0]        r_rb;
  logic              r_cmd_ready, r_rsp_valid, r_rsp_err, r_re, r_we;
  logic [REG_SZ-1:0] r_rsp_a, r_rsp_b, r_din;
  logic [4:0]        r_r_idx, r_w_idx;

  // The FSM state register acts as the final synchronizer stage, so with an
  // instant responder each REQ/REL state lasts exactly SYNC_STAGES cycles.
  if (SW > 1) begin : g_sync_deep
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rack_sync <= '0;
        r_wack_sync <= '0;
      end else begin
        r_rack_sync <= {r_rack_sync[SW-2:0], rf_rack};
        r_wack_sync <= {r_wack_sync[SW-2:0], rf_wack};
      end
    end
  end else begin : g_sync_one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rack_sync <= '0;
        r_wack_sync <= '0;
      end else begin
        r_rack_sync <= rf_rack;
        r_wack_sync <= rf_wack;
      end
    end
  end

  assign w_rack      = r_rack_sync[SW-1];
  assign w_wack      = r_wack_sync[SW-1];
  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_cmd_wr_en = cmd_wr && (cmd_wa != 5'd0);
  assign w_req_enter = (w_state_nxt inside {S_RA_REQ, S_RB_REQ, S_W_REQ}) &&
                       (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid)
                  w_state_nxt = cmd_rd_a    ? S_RA_REQ :
                                cmd_rd_b    ? S_RB_REQ :
                                w_cmd_wr_en ? S_W_REQ  : S_RESP;
      S_RA_REQ: if (w_rack)         w_state_nxt = S_RA_REL;
                else if (w_tmo_hit) w_state_nxt = S_ABORT;
      S_RA_REL: if (!w_rack)
                  w_state_nxt = r_rd_b ? S_RB_REQ : r_wr ? S_W_REQ : S_RESP;
      S_RB_REQ: if (w_rack)         w_state_nxt = S_RB_REL;
                else if (w_tmo_hit) w_state_nxt = S_ABORT;
      S_RB_REL: if (!w_rack)        w_state_nxt = r_wr ? S_W_REQ : S_RESP;
      S_W_REQ:  if (w_wack)         w_state_nxt = S_W_REL;
                else if (w_tmo_hit) w_state_nxt = S_ABORT;
      S_W_REL:  if (!w_wack)        w_state_nxt = S_RESP;
      S_ABORT:  if (!w_rack && !w_wack) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready)      w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_tmo <= '0;
    else if (w_req_enter) r_tmo <= '0;
    else if (r_state inside {S_RA_REQ, S_RB_REQ, S_W_REQ}) r_tmo <= r_tmo + 1'b1;
  end

  // Outputs are decoded from the next state so strobes move on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
      r_r_idx     <= '0;
      r_w_idx     <= '0;
      r_din       <= '0;
      r_rd_b      <= 1'b0;
      r_wr        <= 1'b0;
      r_rb        <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_re        <= (w_state_nxt == S_RA_REQ) || (w_state_nxt == S_RB_REQ);
      r_we        <= (w_state_nxt == S_W_REQ);
      if (w_accept) begin
        r_rd_b  <= cmd_rd_b;
        r_wr    <= w_cmd_wr_en;
        r_rb    <= cmd_rb;
        r_r_idx <= cmd_rd_a ? cmd_ra : cmd_rb;
        r_w_idx <= cmd_wa;
        r_din   <= cmd_wdata;
      end
      if ((r_state == S_RA_REL) && (w_state_nxt == S_RB_REQ)) r_r_idx <= r_rb;
      if ((r_state == S_RA_REQ) && w_rack) r_rsp_a <= rf_dout;
      if ((r_state == S_RB_REQ) && w_rack) r_rsp_b <= rf_dout;
      if ((r_state == S_ABORT) && (w_state_nxt == S_RESP)) r_rsp_err <= 1'b1;
      if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_a   <= '0;
        r_rsp_b   <= '0;
        r_rsp_err <= 1'b0;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_a     = r_rsp_a;
  assign rsp_b     = r_rsp_b;
  assign rf_re     = r_re;
  assign rf_we     = r_we;
  assign rf_r_idx  = r_r_idx;
  assign rf_w_idx  = r_w_idx;
  assign rf_din    = r_din;

endmodule
